// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write bundle for the program loader.
// The loader takes the slave side; the stream source / system takes the master side.
interface instr_mem_loader_if #(
   parameter int INS_ADDRESS = 32,
   parameter int INS_W       = 32
);
   logic                   start;
   logic                   abort;
   logic [7:0]             in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic                   wr_en;
   logic [INS_ADDRESS-1:0] wr_addr;
   logic [INS_W-1:0]       wr_data;
   logic                   cpu_hold;
   logic                   done;
   logic                   error;

   modport slave (
      input  start, abort, in_data, in_valid,
      output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
   );

   modport master (
      output start, abort, in_data, in_valid,
      input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Framed byte-stream loader: length, N little-endian words, XOR checksum.
// Writes each assembled word to instruction memory and holds the core while loading.
module instr_mem_loader #(
   parameter int INS_ADDRESS = 32,
   parameter int INS_W       = 32,
   parameter int MAX_WORDS   = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   instr_mem_loader_if.slave bus
);
   localparam int         WW    = $clog2(MAX_WORDS + 1);
   localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

   state_t                 state_q, state_d;
   logic [WW-1:0]          n_q, n_d;
   logic [WW-1:0]          word_idx_q, word_idx_d;
   logic [1:0]             byte_idx_q, byte_idx_d;
   logic [7:0]             acc_q, acc_d;
   logic [INS_W-1:0]       word_q, word_d;
   logic                   wr_en_q, wr_en_d;
   logic [INS_ADDRESS-1:0] wr_addr_q, wr_addr_d;
   logic [INS_W-1:0]       wr_data_q, wr_data_d;
   logic                   cpu_hold_q, cpu_hold_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;

   logic                   loading;
   logic                   in_ready;
   logic                   accept;
   logic [INS_W-1:0]       word_shift;

   assign loading  = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
   assign in_ready = loading && !bus.abort;
   assign accept   = in_ready && bus.in_valid;

   // Incoming byte lands in lane byte_idx; other lanes keep what is already assembled.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_shift[8*gi +: 8] = (byte_idx_q == 2'(gi)) ? bus.in_data : word_q[8*gi +: 8];
   end

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      acc_d      = acc_q;
      word_d     = word_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      cpu_hold_d = cpu_hold_q;
      done_d     = done_q;
      error_d    = error_q;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (bus.start) begin
               state_d    = LEN;
               done_d     = 1'b0;
               error_d    = 1'b0;
               cpu_hold_d = 1'b1;
               word_idx_d = '0;
               byte_idx_d = '0;
               acc_d      = '0;
               word_d     = '0;
            end
         end
         LEN: begin
            if (bus.abort) begin
               state_d = ERR;
            end else if (accept) begin
               if ((bus.in_data == 8'd0) || (bus.in_data > MAX_N)) begin
                  state_d = ERR;
               end else begin
                  n_d     = WW'(bus.in_data);
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (bus.abort) begin
               state_d = ERR;
            end else if (accept) begin
               word_d     = word_shift;
               acc_d      = acc_q ^ bus.in_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = INS_ADDRESS'(word_idx_q) << 2;
                  wr_data_d  = word_shift;
                  word_idx_d = word_idx_q + 1'b1;
                  if (word_idx_d == n_q) begin
                     state_d = CSUM;
                  end
               end
            end
         end
         CSUM: begin
            if (bus.abort) begin
               state_d = ERR;
            end else if (accept) begin
               state_d = (bus.in_data == acc_q) ? DONE : ERR;
            end
         end
         default: state_d = IDLE;
      endcase

      // Terminal states only entered from a load; flags and hold update on the same edge.
      if (loading && (state_d == DONE)) begin
         done_d     = 1'b1;
         cpu_hold_d = 1'b0;
      end
      if (loading && (state_d == ERR)) begin
         error_d    = 1'b1;
         cpu_hold_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         n_q        <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         acc_q      <= '0;
         word_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cpu_hold_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         acc_q      <= acc_d;
         word_q     <= word_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.cpu_hold = cpu_hold_q;
   assign bus.done     = done_q;
   assign bus.error    = error_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: frame-level reference model checked every cycle,
// plus literal expectations on write logs and status after each directed frame.
module tb_instr_mem_loader;
   localparam int MAX_WORDS = 8;

   logic clk = 1'b0;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   instr_mem_loader_if #(.INS_ADDRESS(32), .INS_W(32)) bus ();

   instr_mem_loader #(
      .INS_ADDRESS (32),
      .INS_W       (32),
      .MAX_WORDS   (MAX_WORDS)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: tracks the accepted bytes of the current frame and derives
   // writes and status from the frame contents.
   bit          m_loading, m_done, m_error, m_hold, m_wr_en;
   logic [31:0] m_wr_addr, m_wr_data;
   logic [7:0]  m_frame[$];

   task automatic model_reset();
      m_loading = 0; m_done = 0; m_error = 0; m_hold = 0; m_wr_en = 0;
      m_wr_addr = '0; m_wr_data = '0;
      m_frame.delete();
   endtask

   task automatic model_finish(input bit ok);
      m_loading = 0;
      m_hold    = 0;
      m_done    = ok;
      m_error   = !ok;
   endtask

   task automatic model_step();
      int         n;
      int         sz;
      logic [7:0] x;
      m_wr_en = 0;
      if (!m_loading) begin
         if (bus.start) begin
            m_loading = 1; m_hold = 1; m_done = 0; m_error = 0;
            m_frame.delete();
         end
      end else if (bus.abort) begin
         model_finish(0);
      end else if (bus.in_valid) begin
         m_frame.push_back(bus.in_data);
         sz = m_frame.size();
         n  = int'(m_frame[0]);
         if (sz == 1) begin
            if (n == 0 || n > MAX_WORDS) model_finish(0);
         end else if (sz - 1 <= 4 * n) begin
            if ((sz - 1) % 4 == 0) begin
               m_wr_en   = 1;
               m_wr_addr = 32'(4 * ((sz - 1) / 4 - 1));
               m_wr_data = {m_frame[sz-1], m_frame[sz-2], m_frame[sz-3], m_frame[sz-4]};
            end
         end else begin
            x = 8'h00;
            for (int i = 1; i <= 4 * n; i++) x = x ^ m_frame[i];
            model_finish(m_frame[sz-1] == x);
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   // Compare process: all outputs against the model, every falling edge.
   logic [63:0] wlog[$];

   initial begin
      bit prev_wr;
      prev_wr = 0;
      forever begin
         @(negedge clk);
         chk("in_ready", bus.in_ready, m_loading && !bus.abort);
         chk("wr_en",    bus.wr_en,    m_wr_en);
         chk("wr_addr",  bus.wr_addr,  m_wr_addr);
         chk("wr_data",  bus.wr_data,  m_wr_data);
         chk("cpu_hold", bus.cpu_hold, m_hold);
         chk("done",     bus.done,     m_done);
         chk("error",    bus.error,    m_error);
         if (bus.wr_en) begin
            chk("wr_en_consecutive", prev_wr, 1'b0);
            wlog.push_back({bus.wr_addr, bus.wr_data});
         end
         prev_wr = bus.wr_en;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] stim[$];

   task automatic step(input logic st, input logic ab, input logic v, input logic [7:0] d);
      bus.start    = st;
      bus.abort    = ab;
      bus.in_valid = v;
      bus.in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send_stim(input int gap_max, input int start_idx);
      for (int i = 0; i < stim.size(); i++) begin
         int g;
         g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         repeat (g) step(0, 0, 0, 8'h00);
         step(i == start_idx, 0, 1, stim[i]);
      end
   endtask

   task automatic good_frame(input logic [7:0] csum);
      stim = {8'h02, 8'h93, 8'h00, 8'h20, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, csum};
   endtask

   task automatic check_two_writes(input string name);
      chk({name, "_nwrites"}, 64'(wlog.size()), 64'd2);
      if (wlog.size() >= 2) begin
         chk({name, "_w0"}, wlog[0], {32'd0, 32'h00200093});
         chk({name, "_w1"}, wlog[1], {32'd4, 32'h00100113});
      end
   endtask

   task automatic report(input string name);
      $display("frame %s: writes=%0d done=%0b error=%0b cpu_hold=%0b",
               name, wlog.size(), bus.done, bus.error, bus.cpu_hold);
   endtask

   task automatic run_abort(input int ndata);
      wlog.delete();
      step(1, 0, 0, 8'h00);
      good_frame(8'hB1);
      for (int i = 0; i <= ndata; i++) step(0, 0, 1, stim[i]);
      step(0, 1, 1, stim[ndata+1]);
      chk("abort_error", bus.error, 1'b1);
      chk("abort_hold",  bus.cpu_hold, 1'b0);
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      chk("abort_nwrites", 64'(wlog.size()), 64'd1);
      report("abort");
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] x;
      logic [31:0] w;

      reset_n      = 1'b0;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_wr_en",    bus.wr_en,    1'b0);
      chk("rst_wr_addr",  bus.wr_addr,  32'd0);
      chk("rst_wr_data",  bus.wr_data,  32'd0);
      chk("rst_cpu_hold", bus.cpu_hold, 1'b0);
      chk("rst_done",     bus.done,     1'b0);
      chk("rst_error",    bus.error,    1'b0);
      reset_n = 1'b1;
      step(0, 1, 0, 8'h00);

      // Good load, then back-to-back start (with abort) in the first DONE cycle.
      wlog.delete();
      step(1, 0, 0, 8'h00);
      chk("good_hold_up", bus.cpu_hold, 1'b1);
      good_frame(8'hB1);
      send_stim(0, -1);
      chk("good_done",  bus.done,     1'b1);
      chk("good_error", bus.error,    1'b0);
      chk("good_hold",  bus.cpu_hold, 1'b0);
      check_two_writes("good");
      report("good");

      wlog.delete();
      step(1, 1, 0, 8'h00);
      chk("b2b_done_cleared", bus.done, 1'b0);
      send_stim(0, -1);
      step(0, 1, 0, 8'h00);
      chk("b2b_done", bus.done, 1'b1);
      check_two_writes("b2b");
      report("back_to_back");

      // Bad checksum: writes still land.
      wlog.delete();
      step(1, 0, 0, 8'h00);
      good_frame(8'hB0);
      send_stim(0, -1);
      step(0, 0, 0, 8'h00);
      chk("badcs_error", bus.error, 1'b1);
      chk("badcs_done",  bus.done,  1'b0);
      check_two_writes("badcs");
      report("bad_checksum");

      // Bad lengths 0 and MAX_WORDS+1; trailing bytes must be refused.
      for (int k = 0; k < 2; k++) begin
         wlog.delete();
         step(1, 0, 0, 8'h00);
         b = (k == 0) ? 8'h00 : 8'h09;
         stim = {b, 8'h11, 8'h22};
         send_stim(0, -1);
         chk("badlen_error",    bus.error,    1'b1);
         chk("badlen_in_ready", bus.in_ready, 1'b0);
         chk("badlen_nwrites",  64'(wlog.size()), 64'd0);
         step(0, 0, 0, 8'h00);
         report(k == 0 ? "bad_len_00" : "bad_len_09");
      end

      // Abort with 3rd byte of word 1, and with the byte right after word 0 completes.
      run_abort(6);
      run_abort(4);

      // 8-word frame with random valid gaps; a stray start mid-frame is ignored.
      wlog.delete();
      step(1, 0, 0, 8'h00);
      stim = {8'h08};
      x = 8'h00;
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 4; j++) begin
            b = 8'(16 * k + 3 * j + 1);
            stim.push_back(b);
            x = x ^ b;
         end
      end
      stim.push_back(x);
      send_stim(2, 5);
      step(0, 0, 0, 8'h00);
      chk("stall_done",    bus.done, 1'b1);
      chk("stall_nwrites", 64'(wlog.size()), 64'd8);
      for (int k = 0; k < wlog.size(); k++) begin
         for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(16 * k + 3 * j + 1);
         chk("stall_write", wlog[k], {32'(4 * k), w});
      end
      report("stall_8_words");

      // Reset mid-frame after one word was written.
      wlog.delete();
      step(1, 0, 0, 8'h00);
      stim = {8'h02, 8'h93, 8'h00, 8'h20, 8'h00, 8'h13, 8'h01};
      send_stim(0, -1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", bus.in_ready, 1'b0);
      chk("mid_rst_wr_en",    bus.wr_en,    1'b0);
      chk("mid_rst_wr_addr",  bus.wr_addr,  32'd0);
      chk("mid_rst_wr_data",  bus.wr_data,  32'd0);
      chk("mid_rst_cpu_hold", bus.cpu_hold, 1'b0);
      chk("mid_rst_done",     bus.done,     1'b0);
      chk("mid_rst_error",    bus.error,    1'b0);
      report("reset_mid_frame");
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(0, 0, 0, 8'h00);
      wlog.delete();
      step(1, 0, 0, 8'h00);
      good_frame(8'hB1);
      send_stim(1, -1);
      step(0, 0, 0, 8'h00);
      chk("post_rst_done", bus.done, 1'b1);
      check_two_writes("post_rst");
      report("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
